// File: rtl/program_counter_if.sv
// Bus between the control/datapath side and the program counter.
// Carries the branch controls and the instruction address the PC drives.
interface program_counter_if;
  logic        SaltoCond;
  logic [31:0] extSigno;
  logic        oZero;
  logic [31:0] direinstrux;

  // Control unit / ALU side: supplies branch controls, reads the address
  modport master (
    output SaltoCond,
    output extSigno,
    output oZero,
    input  direinstrux
  );

  // Program counter side: consumes branch controls, drives the address
  modport slave (
    input  SaltoCond,
    input  extSigno,
    input  oZero,
    output direinstrux
  );
endinterface

// File: rtl/program_counter.sv
// Program counter for the single-cycle datapath.
// Holds the byte address of the current instruction. It advances by 4 every
// clock, or jumps PC-relative when a conditional branch is taken. The output
// is the register itself, so nothing reaches direinstrux combinationally.
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  program_counter_if.slave  bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        branch_taken;

  // Next-address arithmetic. The immediate counts words, so it is shifted into
  // a byte offset. The shift drops the top two immediate bits and keeps the
  // target word-aligned. All sums wrap modulo 2^32, which gives backward
  // branches through two's complement.
  always_comb begin
    pc_plus4      = pc + 32'd4;
    branch_offset = bus.extSigno << 2;
    branch_target = pc_plus4 + branch_offset;
    branch_taken  = bus.SaltoCond & bus.oZero;
    next_pc       = pc_plus4;
    if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // PC register. Reset takes priority over any pending branch or increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= next_pc;
    end
  end

  assign bus.direinstrux = pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// Each test row gives the reset and branch inputs plus the address expected
// after the next rising edge. The expected address goes into a scoreboard
// queue when the inputs are driven. It is popped and compared just after the
// edge.
module tb_program_counter;

  typedef struct {
    logic        rst;
    logic        salto;
    logic        zero;
    logic [31:0] ext;
    logic [31:0] expect_pc;
  } vector_t;

  logic clk;
  logic reset;
  program_counter_if pc_bus ();

  program_counter #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pc_bus)
  );

  // Free-running clock with a 10 time-unit period
  always #5 clk = ~clk;

  logic [31:0] expected_q[$];
  int          tests_run;
  int          tests_failed;
  logic [31:0] model_pc;
  vector_t     vectors[20];

  // Drive one set of inputs on the falling edge and queue the expected result
  task automatic apply_stimulus(input logic rst, input logic salto,
                                input logic zero, input logic [31:0] ext,
                                input logic [31:0] expect_pc);
    @(negedge clk);
    reset            = rst;
    pc_bus.SaltoCond = salto;
    pc_bus.oZero     = zero;
    pc_bus.extSigno  = ext;
    expected_q.push_back(expect_pc);
  endtask

  // Wait for the active edge, then compare the output with the oldest queued value
  task automatic check_output(input string label);
    logic [31:0] exp_pc;
    @(posedge clk);
    #1;
    tests_run++;
    if (expected_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", label, pc_bus.direinstrux);
    end else begin
      exp_pc = expected_q.pop_front();
      if (pc_bus.direinstrux !== exp_pc) begin
        tests_failed++;
        $display("[TB] FAIL %s: direinstrux got %h expected %h",
                 label, pc_bus.direinstrux, exp_pc);
      end
    end
  endtask

  task automatic step(input logic rst, input logic salto, input logic zero,
                      input logic [31:0] ext, input logic [31:0] expect_pc,
                      input string label);
    apply_stimulus(rst, salto, zero, ext, expect_pc);
    check_output(label);
  endtask

  initial begin
    clk              = 1'b0;
    reset            = 1'b1;
    pc_bus.SaltoCond = 1'b0;
    pc_bus.oZero     = 1'b0;
    pc_bus.extSigno  = 32'h0;
    tests_run        = 0;
    tests_failed     = 0;

    // rst, salto, zero, extSigno, expected address after the edge
    vectors[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vectors[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vectors[2]  = '{1'b0, 1'b0, 1'b0, 32'hC000_0001, 32'h0000_0004};
    vectors[3]  = '{1'b0, 1'b0, 1'b0, 32'hC000_0001, 32'h0000_0008};
    vectors[4]  = '{1'b0, 1'b0, 1'b0, 32'hC000_0001, 32'h0000_000C};
    vectors[5]  = '{1'b0, 1'b1, 1'b1, 32'hC000_0001, 32'h0000_0014};
    vectors[6]  = '{1'b0, 1'b1, 1'b1, 32'hC000_0001, 32'h0000_001C};
    vectors[7]  = '{1'b1, 1'b1, 1'b1, 32'hC000_0001, 32'h0000_0000};
    vectors[8]  = '{1'b0, 1'b0, 1'b0, 32'hC000_0001, 32'h0000_0004};
    vectors[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0008};
    vectors[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_000C};
    vectors[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vectors[12] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC};
    vectors[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vectors[14] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vectors[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008};
    vectors[16] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0008};
    vectors[17] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0008};
    vectors[18] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vectors[19] = '{1'b0, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_000C};

    for (int i = 0; i < 20; i++) begin
      step(vectors[i].rst, vectors[i].salto, vectors[i].zero, vectors[i].ext,
           vectors[i].expect_pc, $sformatf("row%0d", i));
    end

    // Forward branch that wraps past the top of the address space
    step(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, "wrap_reset");
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF8, "wrap_back");
    step(1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0008, "wrap_fwd");
    step(1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_000C, "wrap_seq");

    // Reset held for several edges, then a plain release
    step(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, "hold_rst0");
    step(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, "hold_rst1");
    step(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0004, "release");

    // Random traffic checked against an independent address model
    model_pc = 32'h0000_0004;
    for (int i = 0; i < 24; i++) begin
      logic        r;
      logic        s;
      logic        z;
      logic [31:0] e;
      logic [31:0] offs;
      r    = (i == 12);
      s    = 1'($urandom_range(0, 1));
      z    = 1'($urandom_range(0, 1));
      e    = $urandom;
      offs = {e[29:0], 2'b00};
      if (r)
        model_pc = 32'h0000_0000;
      else if (s && z)
        model_pc = model_pc + 32'd4 + offs;
      else
        model_pc = model_pc + 32'd4;
      step(r, s, z, e, model_pc, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
